// File: rtl/ssd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_mux
//  Purpose  : Time-multiplexed 7-segment scanner with dead time, per-digit
//             enable, decimal points, leading-zero blanking and frame snapshot.
//             Optional dimming is built when SSD_DIM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 262144,
    parameter int BLANK_CYCLES = 1024,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
`ifdef SSD_DIM_EN
    input  logic [3:0]              brightness,
`endif
    output logic [NUM_DIGITS-1:0]   An,
    output logic [7:0]              Cathodes,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_tick
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] C_BLANK    = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_en_q;
    logic                    snap_lz_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              cath_q, cath_d;
    logic [IDX_W-1:0]        scan_idx_q;
    logic                    tick_q;

    logic                    w_frame_start;
    logic [4*NUM_DIGITS-1:0] w_dig;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_en;
    logic                    w_lz;
    logic [NUM_DIGITS-1:0]   w_lz_blanked;
    logic                    w_all_zero;
    logic [3:0]              w_nib;
    logic                    w_dp_cur;
    logic                    w_show;
    logic                    w_active;
    logic                    w_dim_on;
    logic [7:0]              w_seg;

    function automatic logic [7:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: seg_lut = 8'h03;
            4'h1: seg_lut = 8'h9F;
            4'h2: seg_lut = 8'h25;
            4'h3: seg_lut = 8'h0D;
            4'h4: seg_lut = 8'h99;
            4'h5: seg_lut = 8'h49;
            4'h6: seg_lut = 8'h41;
            4'h7: seg_lut = 8'h1F;
            4'h8: seg_lut = 8'h01;
            4'h9: seg_lut = 8'h09;
            4'hA: seg_lut = 8'h11;
            4'hB: seg_lut = 8'hC1;
            4'hC: seg_lut = 8'h63;
            4'hD: seg_lut = 8'h85;
            4'hE: seg_lut = 8'h61;
            default: seg_lut = 8'h71;
        endcase
    endfunction

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // On the capture cycle the live inputs are used so the frame is consistent
    // even when BLANK_CYCLES is zero.
    assign w_frame_start = (cnt_q == '0) && (idx_q == '0);
    assign w_dig = w_frame_start ? digits_in : snap_dig_q;
    assign w_dp  = w_frame_start ? dp_in     : snap_dp_q;
    assign w_en  = w_frame_start ? digit_en  : snap_en_q;
    assign w_lz  = w_frame_start ? lz_blank  : snap_lz_q;

    always_comb begin
        w_all_zero   = 1'b1;
        w_lz_blanked = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_all_zero      = w_all_zero & (~w_en[k] | (w_dig[4*k +: 4] == 4'h0));
            w_lz_blanked[k] = w_lz & w_all_zero & (k != 0);
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dp_cur = 1'b0;
        w_show   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_nib    = w_dig[4*k +: 4];
                w_dp_cur = w_dp[k];
                w_show   = w_en[k] & ~w_lz_blanked[k];
            end
        end
    end

`ifdef SSD_DIM_EN
    logic [3:0] w_cnt_lo;
    if (CNT_W >= 4) begin : g_cnt_lo_wide
        assign w_cnt_lo = cnt_q[3:0];
    end else begin : g_cnt_lo_narrow
        assign w_cnt_lo = {{(4-CNT_W){1'b0}}, cnt_q};
    end
    assign w_dim_on = (brightness == 4'hF) || (w_cnt_lo < brightness);
`else
    assign w_dim_on = 1'b1;
`endif

    assign w_active = (cnt_q >= C_BLANK) && w_show;
    assign w_seg    = seg_lut(w_nib);

    // Dimming gates only the anode; cathodes keep the digit pattern.
    always_comb begin
        cath_d = w_active ? {w_seg[7:1], ~w_dp_cur} : 8'hFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = ~(w_active && w_dim_on && (idx_q == IDX_W'(k)));
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_en_q  <= '0;
            snap_lz_q  <= 1'b0;
            an_q       <= '1;
            cath_q     <= 8'hFF;
            scan_idx_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (w_frame_start) begin
                snap_dig_q <= digits_in;
                snap_dp_q  <= dp_in;
                snap_en_q  <= digit_en;
                snap_lz_q  <= lz_blank;
            end
            an_q       <= an_d;
            cath_q     <= cath_d;
            scan_idx_q <= idx_q;
            tick_q     <= w_frame_start;
        end
    end

    assign An         = an_q;
    assign Cathodes   = cath_q;
    assign scan_idx   = scan_idx_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_mux
//  Purpose  : Randomized self-checking bench for ssd_scan_mux (4 digits,
//             16-cycle slots, 2 blank cycles) against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssd_scan_mux;

    localparam int NUM_DIGITS = 4;
    localparam int PRESCALE   = 16;
    localparam int BLANK      = 2;

    logic        ClkPort = 1'b0;
    logic        Reset   = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in     = '0;
    logic [3:0]  digit_en  = '0;
    logic        lz_blank  = 1'b0;
`ifdef SSD_DIM_EN
    logic [3:0]  brightness = 4'hF;
`endif
    logic [3:0]  An;
    logic [7:0]  Cathodes;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    ssd_scan_mux #(
        .NUM_DIGITS  (NUM_DIGITS),
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK)
    ) u_dut (
        .ClkPort   (ClkPort),
        .Reset     (Reset),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .lz_blank  (lz_blank),
`ifdef SSD_DIM_EN
        .brightness(brightness),
`endif
        .An        (An),
        .Cathodes  (Cathodes),
        .scan_idx  (scan_idx),
        .frame_tick(frame_tick)
    );

    always #5 ClkPort = ~ClkPort;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;

    logic [7:0]  SEG [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    logic [15:0] s_dig;
    logic [3:0]  s_dp, s_en;
    logic        s_lz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    endtask

    // One clock of the reference: position in frame from elapsed cycles.
    task automatic step();
        int cnt, slot, msd;
        logic shown, act, act_an;
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [7:0] e_cath, seg;
        cnt  = t % PRESCALE;
        slot = (t / PRESCALE) % NUM_DIGITS;
        if (cnt == 0 && slot == 0) begin
            s_dig = digits_in; s_dp = dp_in; s_en = digit_en; s_lz = lz_blank;
        end
        msd = 0;
        for (int j = 0; j < NUM_DIGITS; j++)
            if (s_en[j] && s_dig[4*j +: 4] != 4'h0) msd = j;
        shown  = s_en[slot] && !(s_lz && slot > msd);
        act    = (cnt >= BLANK) && shown;
        act_an = act;
`ifdef SSD_DIM_EN
        act_an = act && (brightness == 4'hF || cnt < int'(brightness));
`endif
        nib    = s_dig[4*slot +: 4];
        seg    = SEG[nib];
        e_an   = act_an ? ~(4'b0001 << slot) : 4'hF;
        e_cath = act ? {seg[7:1], ~s_dp[slot]} : 8'hFF;
        @(posedge ClkPort); #1;
        check("An", 32'(An), 32'(e_an));
        check("Cathodes", 32'(Cathodes), 32'(e_cath));
        check("scan_idx", 32'(scan_idx), slot);
        check("frame_tick", 32'(frame_tick), 32'(cnt == 0 && slot == 0));
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < NUM_DIGITS; k++)
            digits_in[4*k +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
        dp_in    = 4'($urandom);
        digit_en = ($urandom_range(2) == 0) ? 4'($urandom) : 4'hF;
        lz_blank = 1'($urandom);
`ifdef SSD_DIM_EN
        case ($urandom_range(2))
            0: brightness = 4'h0;
            1: brightness = 4'hF;
            default: brightness = 4'($urandom);
        endcase
`endif
    endtask

    initial begin
        repeat (2) @(negedge ClkPort);
        check("rst_An", 32'(An), 32'hF);
        check("rst_Cathodes", 32'(Cathodes), 32'hFF);
        check("rst_scan_idx", 32'(scan_idx), 32'h0);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);

        digits_in = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; lz_blank = 1'b0;
        @(negedge ClkPort); Reset = 1'b0; t = 0;
        run(40);

        // Asynchronous reset in the middle of slot 2.
        #2 Reset = 1'b1;
        #1;
        check("midrst_An", 32'(An), 32'hF);
        check("midrst_Cathodes", 32'(Cathodes), 32'hFF);
        check("midrst_scan_idx", 32'(scan_idx), 32'h0);
        check("midrst_frame_tick", 32'(frame_tick), 32'h0);
        @(negedge ClkPort); Reset = 1'b0; t = 0;
        run(128);

        lz_blank = 1'b1; digits_in = 16'h0050; dp_in = 4'b0001;
        run(128);

        lz_blank = 1'b0; digits_in = 16'h1234; dp_in = 4'h0; digit_en = 4'b0101;
        run(128);

        digit_en = 4'hF; digits_in = 16'h1111;
        while ((t % 64) != 0) step();
        run(32 + 5);
        digits_in = 16'h2222;
        run(64 + 27 + 64);

`ifdef SSD_DIM_EN
        brightness = 4'h4; run(64);
        brightness = 4'h0; run(64);
        brightness = 4'hF; run(64);
`endif

        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(7) == 0) rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
